pet_stats_engine: RTL

//  Parametrised successor of the pet stats/status path: holds NUM_STATS saturating stat counters,

---
 rtl/pet_stats_if.sv | 26 ++
 rtl/pet_stats_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pet_stats_if.sv
// Pet stats engine bus: action handshake, random source, tick pulse and status outputs.
//   master: drives action_valid/action_id/rand_in, observes everything else.
//   slave : the engine; drives action_ready, tick_out, stats_flat, critical_mask, mood.
interface pet_stats_if #(
    parameter int unsigned NUM_STATS = 6,
    parameter int unsigned STAT_W    = 4
);
    logic                          action_valid;
    logic [2:0]                    action_id;
    logic                          action_ready;
    logic [3:0]                    rand_in;
    logic                          tick_out;
    logic [NUM_STATS*STAT_W-1:0]   stats_flat;
    logic [NUM_STATS-1:0]          critical_mask;
    logic [1:0]                    mood;

    modport master (
        output action_valid, action_id, rand_in,
        input  action_ready, tick_out, stats_flat, critical_mask, mood
    );

    modport slave (
        input  action_valid, action_id, rand_in,
        output action_ready, tick_out, stats_flat, critical_mask, mood
    );
endinterface

// File: rtl/pet_stats_engine.sv
// Pet stat counters: saturating stats decayed one-per-cycle on each prescaled tick,
// boosted by accepted user actions, with a registered mood code and critical mask.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pet_stats_if slave (action valid/ready/id, rand_in, tick_out,
//              stats_flat, critical_mask, mood)
module pet_stats_engine #(
    parameter int unsigned NUM_STATS   = 6,
    parameter int unsigned STAT_W      = 4,
    parameter int unsigned TICK_DIV    = 10_000_000,
    parameter int unsigned DECAY_STEP  = 1,
    parameter int unsigned ACTION_GAIN = 4,
    parameter int unsigned CRIT_LEVEL  = 3,
    parameter int unsigned RESET_VAL   = 8
) (
    input  logic clk,
    input  logic rst,
    pet_stats_if.slave bus
);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned SMAX  = (1 << STAT_W) - 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] MOOD_HAPPY = 2'd0;
    localparam logic [1:0] MOOD_NEEDY = 2'd1;
    localparam logic [1:0] MOOD_SICK  = 2'd2;
    localparam logic [1:0] MOOD_DEAD  = 2'd3;

    typedef enum logic [1:0] {IDLE, DECAY, EVAL, DEAD} state_t;

    state_t                             state_q, state_d;
    logic [PRE_W-1:0]                   presc_q;
    logic                               tick_q;
    logic                               tick_pend_q;
    logic                               consume_c;
    logic [2:0]                         idx_q, idx_d;
    logic [3:0]                         rsel_q, rsel_d;
    logic [NUM_STATS-1:0][STAT_W-1:0]   stats_q, stats_d;
    logic [NUM_STATS-1:0]               mask_q, mask_d;
    logic [1:0]                         mood_q, mood_d;

    logic                               wrap_c;
    logic [NUM_STATS-1:0]               crit_c;
    logic [CNT_W-1:0]                   ncrit_c;
    logic                               all_zero_c;
    logic [STAT_W:0]                    dec_c;

    assign wrap_c = (presc_q == PRE_W'(TICK_DIV - 1));

    // Add with saturation at SMAX using a one-bit-wider intermediate.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v);
        logic [STAT_W:0] sum;
        sum = {1'b0, v} + (STAT_W+1)'(ACTION_GAIN);
        return (sum > (STAT_W+1)'(SMAX)) ? STAT_W'(SMAX) : sum[STAT_W-1:0];
    endfunction

    // Subtract with floor at zero.
    function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] v,
                                                  input logic [STAT_W:0]   d);
        logic [STAT_W:0] diff;
        diff = {1'b0, v} - d;
        return ({1'b0, v} < d) ? '0 : diff[STAT_W-1:0];
    endfunction

    // Status view of the live stats, sampled into mask/mood only in EVAL.
    always_comb begin
        crit_c     = '0;
        ncrit_c    = '0;
        all_zero_c = 1'b1;
        for (int i = 0; i < NUM_STATS; i++) begin
            crit_c[i] = (stats_q[i] <= STAT_W'(CRIT_LEVEL));
            ncrit_c   = ncrit_c + CNT_W'(crit_c[i]);
            if (stats_q[i] != '0) all_zero_c = 1'b0;
        end
    end

    // Decrement for the stat under the sweep; the randomly selected one loses one more.
    assign dec_c = (STAT_W+1)'(DECAY_STEP) +
                   (STAT_W+1)'((rsel_q == {1'b0, idx_q}) ? 1 : 0);

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        stats_d   = stats_q;
        idx_d     = idx_q;
        rsel_d    = rsel_q;
        mask_d    = mask_q;
        mood_d    = mood_q;
        consume_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_pend_q) begin
                    rsel_d    = bus.rand_in;
                    idx_d     = 3'd0;
                    consume_c = 1'b1;
                    state_d   = DECAY;
                end else if (bus.action_valid) begin
                    // Out-of-range ids are accepted but touch nothing.
                    for (int i = 0; i < NUM_STATS; i++) begin
                        if (bus.action_id == 3'(i)) stats_d[i] = sat_add(stats_q[i]);
                    end
                    state_d = EVAL;
                end
            end
            DECAY: begin
                for (int i = 0; i < NUM_STATS; i++) begin
                    if (idx_q == 3'(i)) stats_d[i] = sat_sub(stats_q[i], dec_c);
                end
                if (idx_q == 3'(NUM_STATS - 1)) state_d = EVAL;
                else                            idx_d   = idx_q + 3'd1;
            end
            EVAL: begin
                mask_d = crit_c;
                if (all_zero_c)                mood_d = MOOD_DEAD;
                else if (ncrit_c >= CNT_W'(3)) mood_d = MOOD_SICK;
                else if (ncrit_c != '0)        mood_d = MOOD_NEEDY;
                else                           mood_d = MOOD_HAPPY;
                state_d = all_zero_c ? DEAD : IDLE;
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            tick_pend_q <= 1'b0;
            idx_q       <= '0;
            rsel_q      <= '0;
            stats_q     <= {NUM_STATS{STAT_W'(RESET_VAL)}};
            mask_q      <= '0;
            mood_q      <= MOOD_HAPPY;
        end else begin
            state_q     <= state_d;
            presc_q     <= wrap_c ? '0 : presc_q + PRE_W'(1);
            // Registered copy of the wrap so tick_out lines up with presc==TICK_DIV-1.
            tick_q      <= (presc_q == PRE_W'(TICK_DIV - 2));
            // A new wrap wins over consumption; a second pending tick is absorbed.
            tick_pend_q <= wrap_c | (tick_pend_q & ~consume_c);
            idx_q       <= idx_d;
            rsel_q      <= rsel_d;
            stats_q     <= stats_d;
            mask_q      <= mask_d;
            mood_q      <= mood_d;
        end
    end

    assign bus.action_ready  = (state_q == IDLE) && !tick_pend_q;
    assign bus.tick_out      = tick_q;
    assign bus.stats_flat    = stats_q;
    assign bus.critical_mask = mask_q;
    assign bus.mood          = mood_q;
endmodule
